// File: rtl/ls_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ls_sched_pkg
// Description : Shared types and constants for the load/store scheduler.
//               state_t   - scheduler FSM states (IDLE, XFER, DONE)
//               DIR_FILL  - direction code for a filling (load) requester
//               DIR_DRAIN - direction code for a draining (store) requester
// Revision    : 1.0  initial release
// ============================================================================
package ls_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_FILL  = 1'b1;
  localparam logic DIR_DRAIN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Returns the first eligible
//               index at or after the pointer, wrapping around NREQ.
// Ports       : eligible [NREQ] in  - candidate mask
//               ptr      [IW]   in  - highest-priority index
//               pick     [NREQ] out - one-hot winner, zero when none eligible
//               pick_idx [IW]   out - binary index of the winner
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import ls_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx
);

  always_comb begin
    logic found;
    int   idx;
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NREQ; i++) begin
      // Walk from the pointer upward, wrapping without a modulo operator.
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = IW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/load_store_sched.sv
`default_nettype none
// ============================================================================
// Module      : load_store_sched
// Description : Round-robin scheduler sharing one saturating volume counter
//               among NREQ fill/drain requesters. A grant moves up to BURST
//               units, one per cycle, then releases for one done cycle and
//               one idle arbitration cycle.
// Options     : LS_SCHED_WM_EN - adds hi_wm/lo_wm outputs and watermark
//               class preference in arbitration (drainers when high,
//               fillers when low).
// Ports       : clk   in  - rising-edge clock
//               rst   in  - asynchronous active-low reset
//               req   in  - per-requester request
//               dir   in  - per-requester direction, 1 fill / 0 drain
//               gnt   out - one-hot grant
//               level out - current volume 0..CAP
//               full  out - level == CAP
//               empty out - level == 0
//               done  out - one-cycle pulse after the last beat of a grant
//               hi_wm out - (option) level >= HI_WM
//               lo_wm out - (option) level <= LO_WM
// Revision    : 1.0  initial release
// ============================================================================
module load_store_sched
  import ls_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CAP   = 15000,
  parameter int CBITS = 14,
  parameter int BURST = 16,
  parameter int HI_WM = 12000,
  parameter int LO_WM = 3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  dir,
  output logic [NREQ-1:0]  gnt,
  output logic [CBITS-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             done
`ifdef LS_SCHED_WM_EN
  ,
  output logic             hi_wm,
  output logic             lo_wm
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);

  if (NREQ < 2 || BURST < 1 || CAP >= (1 << CBITS) || HI_WM < 0 || LO_WM < 0)
  begin : g_param_check
    $error("load_store_sched: illegal parameter combination");
  end

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gidx;
  logic              dir_l;
  logic [BW-1:0]     beats;

  logic [NREQ-1:0]   elig_base;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   pick;
  logic [IW-1:0]     pick_idx;
  logic              beat;
  logic              last;
  logic [CBITS-1:0]  level_nxt;

  assign full  = (level == CBITS'(CAP));
  assign empty = (level == '0);

  // A fill cannot start while full, a drain cannot start while empty.
  assign elig_base = req & ~(dir & {NREQ{full}}) & ~(~dir & {NREQ{empty}});

`ifdef LS_SCHED_WM_EN
  always_comb begin
    logic [NREQ-1:0] drainers;
    logic [NREQ-1:0] fillers;
    drainers = elig_base & ~dir;
    fillers  = elig_base & dir;
    if (hi_wm && |drainers)     elig = drainers;
    else if (lo_wm && |fillers) elig = fillers;
    else                        elig = elig_base;
  end
`else
  assign elig = elig_base;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .eligible (elig),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // A beat happens only while the granted requester still holds req.
  assign beat = (state == XFER) && |(req & gnt);

  always_comb begin
    level_nxt = level;
    if (beat) begin
      if (dir_l == DIR_FILL) level_nxt = level + CBITS'(1);
      else                   level_nxt = level - CBITS'(1);
    end
  end

  // The end test looks at the post-beat level so a transfer stops exactly
  // at the boundary instead of attempting one more beat.
  assign last = !beat
             || (beats + BW'(1) == BW'(BURST))
             || (dir_l == DIR_FILL  && level_nxt == CBITS'(CAP))
             || (dir_l == DIR_DRAIN && level_nxt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      gnt    <= '0;
      level  <= '0;
      done   <= 1'b0;
      rr_ptr <= '0;
      gidx   <= '0;
      dir_l  <= DIR_DRAIN;
      beats  <= '0;
`ifdef LS_SCHED_WM_EN
      hi_wm  <= 1'b0;
      lo_wm  <= 1'b1;
`endif
    end else begin
      if (beat) begin
        assert (!(dir_l == DIR_FILL  && level == CBITS'(CAP)) &&
                !(dir_l == DIR_DRAIN && level == '0))
          else $error("load_store_sched: level would wrap");
      end

      level <= level_nxt;
`ifdef LS_SCHED_WM_EN
      hi_wm <= (int'(level_nxt) >= HI_WM);
      lo_wm <= (int'(level_nxt) <= LO_WM);
`endif

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (|elig) begin
            gnt   <= pick;
            gidx  <= pick_idx;
            dir_l <= dir[pick_idx];
            beats <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (beat) beats <= beats + BW'(1);
          if (last) begin
            gnt   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done   <= 1'b0;
          rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
          state  <= IDLE;
        end
        default: begin
          gnt   <= '0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_sched
// Description : Directed self-checking bench for load_store_sched with
//               NREQ=4, CAP=20, CBITS=5, BURST=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] dir;
  logic [3:0] gnt;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       done;
`ifdef LS_SCHED_WM_EN
  logic       hi_wm;
  logic       lo_wm;
`endif

  int n_checks;
  int n_pass;

  load_store_sched #(
    .NREQ  (4),
    .CAP   (20),
    .CBITS (5),
    .BURST (4),
    .HI_WM (15),
    .LO_WM (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .dir   (dir),
    .gnt   (gnt),
    .level (level),
    .full  (full),
    .empty (empty),
    .done  (done)
`ifdef LS_SCHED_WM_EN
    ,
    .hi_wm (hi_wm),
    .lo_wm (lo_wm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt != 4'b0) break;
    end
    check(tag, int'(gnt != 4'b0), 1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done) break;
    end
    check(tag, int'(done), 1);
  endtask

  initial begin
    int bad;
    int exp_lvl;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    req = 4'b0001;
    dir = 4'b0001;

    // Reset state
    #2;
    check("rst_gnt",   int'(gnt),   0);
    check("rst_level", int'(level), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_done",  int'(done),  0);
    tick();
    rst = 1'b1;

    // Single fill grant: grant one cycle after req seen, 4 beats, done pulse
    tick();
    check("s1_gnt",    int'(gnt),   1);
    check("s1_lvl0",   int'(level), 0);
    tick();
    check("s1_lvl1",   int'(level), 1);
    tick();
    tick();
    tick();
    check("s1_lvl4",   int'(level), 4);
    check("s1_gnt_off",int'(gnt),   0);
    check("s1_done",   int'(done),  1);
    req = 4'b0000;
    tick();
    check("s1_done_1cy", int'(done), 0);

    // All requesters filling: round-robin order, saturate at CAP
    req = 4'b1111;
    dir = 4'b1111;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr_gnt_seen");
      check("rr_gnt", int'(gnt), 1 << (k % 4));
      wait_done("rr_done_seen");
      exp_lvl = (4 * (k + 1) > 20) ? 20 : 4 * (k + 1);
      check("rr_level", int'(level), exp_lvl);
    end
    check("rr_full", int'(full), 1);
    tick();
    tick();
    tick();
    check("full_no_fill_gnt", int'(gnt), 0);

    // Full: only the drainer may be granted even though rr points at the filler
    req = 4'b0011;
    dir = 4'b0010;
    wait_gnt("full_gnt_seen");
    check("full_drain_gnt", int'(gnt), 1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt == 4'b0010) bad++;
      if (done) break;
    end
    check("full_filler_never", bad, 0);
    check("full_drain_level", int'(level), 16);
    req = 4'b0000;
    tick();

    // Voluntary drop after 2 beats, then drain from 2 ends early at 0
    req = 4'b0001;
    dir = 4'b0001;
    do_reset();
    wait_gnt("drop_gnt_seen");
    check("drop_gnt", int'(gnt), 1);
    tick();
    tick();
    check("drop_lvl2", int'(level), 2);
    req = 4'b0000;
    tick();
    check("drop_level", int'(level), 2);
    check("drop_done",  int'(done),  1);
    check("drop_gnt_off", int'(gnt), 0);
    tick();
    req = 4'b0011;
    dir = 4'b0000;
    tick();
    check("rr_advanced_gnt", int'(gnt), 2);
    tick();
    check("drain_lvl1", int'(level), 1);
    tick();
    check("drain_lvl0",  int'(level), 0);
    check("drain_empty", int'(empty), 1);
    check("drain_done",  int'(done),  1);
    check("drain_gnt_off", int'(gnt), 0);
    req = 4'b0000;
    tick();

    // Asynchronous reset in the middle of a transfer at level 11
    req = 4'b0001;
    dir = 4'b0001;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (level == 5'd11) break;
    end
    check("mid_lvl11", int'(level), 11);
    check("mid_gnt",   int'(gnt),   1);
    #2;
    rst = 1'b0;
    #1;
    check("async_gnt",   int'(gnt),   0);
    check("async_level", int'(level), 0);
    check("async_done",  int'(done),  0);
    tick();
    check("async_no_done", int'(done), 0);
    rst = 1'b1;
    req = 4'b0000;
    tick();

`ifdef LS_SCHED_WM_EN
    // Above HI_WM the drainer wins although rr points at the filler
    req = 4'b1000;
    dir = 4'b1000;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_gnt("wm_fill_gnt_seen");
      wait_done("wm_fill_done_seen");
    end
    req = 4'b0011;
    dir = 4'b0001;
    check("wm_level", int'(level), 16);
    tick();
    check("wm_hi", int'(hi_wm), 1);
    check("wm_lo", int'(lo_wm), 0);
    wait_gnt("wm_gnt_seen");
    check("wm_drainer_wins", int'(gnt), 2);
    req = 4'b0000;
    wait_done("wm_done_seen");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
